// File: rtl/led_pkg.sv
// Shared types and helpers for the LED flash sequencer.
package led_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } led_state_e;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_flash_array_if.sv
// Request/status bundle between the byte-stream consumer and the LED sequencer.
interface led_flash_array_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS*CNT_W-1:0] data;
  logic [CHANNELS-1:0]       data_ready;
  logic [CHANNELS-1:0]       busy;
  logic [CHANNELS-1:0]       done;
  logic [CHANNELS-1:0]       overrun;
  logic [CHANNELS-1:0]       led;

  modport master (output data, data_ready, input busy, done, overrun, led);
  modport slave  (input data, data_ready, output busy, done, overrun, led);
endinterface

// File: rtl/led_flash_channel.sv
// One LED channel: flash FSM, phase counter, remaining counter, one-entry pending slot.
// Outputs are registered from the next-state values so led/busy change on the edge
// that accepts or finishes a request.
module led_flash_channel
  import led_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int PERIOD_CYC = 13_500_000,
  parameter int ON_CYC     = 6_750_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [CNT_W-1:0] req_cnt,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic             lit
);
  localparam int              PH_W    = cnt_w(PERIOD_CYC);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD_CYC - 1);
  localparam logic [PH_W-1:0] PH_ON   = PH_W'(ON_CYC);

  led_state_e       state, st_n;
  logic [PH_W-1:0]  phase, ph_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic             pend_vld, pv_n;
  logic [CNT_W-1:0] pend_cnt, pc_n;
  logic             done_n, ovr_n;

  // Next-state: accept/launch requests, advance phase, finish or chain sequences.
  always_comb begin
    st_n   = state;
    ph_n   = phase;
    rem_n  = rem;
    pv_n   = pend_vld;
    pc_n   = pend_cnt;
    done_n = 1'b0;
    ovr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_vld) begin
          // Pending left over from a completion edge: launch it (or finish a zero count).
          pv_n = 1'b0;
          if (pend_cnt != '0) begin
            st_n  = FLASH;
            ph_n  = '0;
            rem_n = pend_cnt;
          end else begin
            done_n = 1'b1;
          end
          if (req) begin
            pv_n = 1'b1;
            pc_n = req_cnt;
          end
        end else if (req) begin
          if (req_cnt != '0) begin
            st_n  = FLASH;
            ph_n  = '0;
            rem_n = req_cnt;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      FLASH: begin
        if (phase == PH_LAST) begin
          ph_n  = '0;
          rem_n = rem - 1'b1;
          if (rem == CNT_W'(1)) begin
            done_n = 1'b1;
            st_n   = IDLE;
            // Chain a nonzero pending count with no gap; a zero count is retired from IDLE.
            if (pend_vld && pend_cnt != '0) begin
              st_n  = FLASH;
              rem_n = pend_cnt;
              pv_n  = 1'b0;
            end
          end
        end else begin
          ph_n = phase + 1'b1;
        end
        // New request lands in the slot; overrun only if it displaces a live entry.
        if (req) begin
          ovr_n = pv_n;
          pv_n  = 1'b1;
          pc_n  = req_cnt;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= '0;
      rem      <= '0;
      pend_vld <= 1'b0;
      pend_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      lit      <= 1'b0;
    end else begin
      state    <= st_n;
      phase    <= ph_n;
      rem      <= rem_n;
      pend_vld <= pv_n;
      pend_cnt <= pc_n;
      busy     <= (st_n == FLASH) | pv_n;
      done     <= done_n;
      overrun  <= ovr_n;
      lit      <= (st_n == FLASH) && (ph_n < PH_ON);
    end
  end

endmodule

// File: rtl/led_flash_array.sv
// Multi-channel LED flash sequencer: independent channels, pin polarity applied here.
module led_flash_array
  import led_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 8,
  parameter int PERIOD_CYC = 13_500_000,
  parameter int ON_CYC     = 6_750_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  led_flash_array_if.slave  bus
);
  logic [CHANNELS-1:0] lit;

  // One sequencer per channel, each fed its own slice of the data bus.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_flash_channel #(
      .CNT_W      (CNT_W),
      .PERIOD_CYC (PERIOD_CYC),
      .ON_CYC     (ON_CYC)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus.data_ready[i]),
      .req_cnt (bus.data[i*CNT_W +: CNT_W]),
      .busy    (bus.busy[i]),
      .done    (bus.done[i]),
      .overrun (bus.overrun[i]),
      .lit     (lit[i])
    );
  end

  // Lit flag is registered; the constant XOR only selects pin polarity.
  assign bus.led = lit ^ {CHANNELS{ACTIVE_LOW}};

endmodule

// File: tb/tb_led_flash_array.sv
// Bench: timeline-based reference model (start edge + count -> led/done timing),
// directed scenarios with literal expectations, then randomized traffic.
module tb_led_flash_array;
  localparam int CH = 2, CW = 4, P = 10, ON = 4;
  localparam bit AL = 1'b0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  led_flash_array_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  led_flash_array #(
    .CHANNELS(CH), .CNT_W(CW), .PERIOD_CYC(P), .ON_CYC(ON), .ACTIVE_LOW(AL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: a running job is (start edge, count); a pending slot holds one count.
  bit     m_act [CH];
  longint m_t0  [CH];
  int     m_n   [CH];
  bit     m_pv  [CH];
  int     m_pn  [CH];
  bit     e_done[CH];
  bit     e_ovr [CH];
  longint edge_no = 0;

  int     n_done[CH], n_ovr[CH], n_lit[CH];
  longint last_done[CH];
  int     tests = 0, fails = 0;

  function automatic void start_job(int c, int n);
    m_act[c] = 1'b1;
    m_t0[c]  = edge_no;
    m_n[c]   = n;
  endfunction

  task automatic model_step();
    edge_no++;
    for (int c = 0; c < CH; c++) begin
      bit req;
      int d;
      req = bus.data_ready[c];
      d   = int'(bus.data[c*CW +: CW]);
      e_done[c] = 1'b0;
      e_ovr[c]  = 1'b0;
      if (!rst_n) begin
        m_act[c] = 1'b0;
        m_pv[c]  = 1'b0;
      end else if (m_act[c]) begin
        if (edge_no - m_t0[c] == longint'(m_n[c]) * P) begin
          e_done[c] = 1'b1;
          m_act[c]  = 1'b0;
          if (m_pv[c] && m_pn[c] != 0) begin
            start_job(c, m_pn[c]);
            m_pv[c] = 1'b0;
          end
        end
        if (req) begin
          e_ovr[c] = m_pv[c];
          m_pv[c]  = 1'b1;
          m_pn[c]  = d;
        end
      end else if (m_pv[c]) begin
        m_pv[c] = 1'b0;
        if (m_pn[c] != 0) start_job(c, m_pn[c]);
        else e_done[c] = 1'b1;
        if (req) begin
          m_pv[c] = 1'b1;
          m_pn[c] = d;
        end
      end else if (req) begin
        if (d != 0) start_job(c, d);
        else e_done[c] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Compare every output of every channel against the model; keep tallies.
  task automatic check();
    for (int c = 0; c < CH; c++) begin
      bit lit_e;
      lit_e = m_act[c] && (((edge_no - m_t0[c]) % P) < ON);
      chk($sformatf("led[%0d]", c),     bus.led[c],     lit_e ^ AL);
      chk($sformatf("busy[%0d]", c),    bus.busy[c],    m_act[c] | m_pv[c]);
      chk($sformatf("done[%0d]", c),    bus.done[c],    e_done[c]);
      chk($sformatf("overrun[%0d]", c), bus.overrun[c], e_ovr[c]);
      if (bus.done[c]) begin
        n_done[c]++;
        last_done[c] = edge_no;
      end
      if (bus.overrun[c]) n_ovr[c]++;
      if (bus.led[c] ^ AL) n_lit[c]++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check();
  endtask

  task automatic strobe(input int c, input int d);
    bus.data_ready[c] = 1'b1;
    bus.data[c*CW +: CW] = CW'(d);
    cyc();
    bus.data_ready[c] = 1'b0;
  endtask

  task automatic clr_tally();
    for (int c = 0; c < CH; c++) begin
      n_done[c] = 0; n_ovr[c] = 0; n_lit[c] = 0; last_done[c] = 0;
    end
  endtask

  initial begin
    longint s;
    for (int c = 0; c < CH; c++) begin
      m_act[c] = 0; m_pv[c] = 0; m_t0[c] = 0; m_n[c] = 0; m_pn[c] = 0;
      e_done[c] = 0; e_ovr[c] = 0;
    end
    bus.data = '0;
    bus.data_ready = '0;
    rst_n = 1'b0;
    @(negedge clk);
    repeat (3) cyc();
    chk("rst_led", bus.led, '0);
    chk("rst_busy", bus.busy, '0);
    chk("rst_done", bus.done, '0);
    chk("rst_overrun", bus.overrun, '0);
    rst_n = 1'b1;
    cyc();

    // Count 3: done 30 edges after strobe, 3 x 4 lit cycles.
    clr_tally();
    strobe(0, 3); s = edge_no;
    repeat (35) cyc();
    chk("d3_done_offset", last_done[0] - s, 30);
    chk("d3_lit_cycles", n_lit[0], 12);
    chk("d3_done_count", n_done[0], 1);
    chk("d3_busy_after", bus.busy[0], 0);

    // Count 0: done next cycle, never lit, never busy.
    clr_tally();
    strobe(0, 0);
    chk("d0_done", bus.done[0], 1);
    chk("d0_busy", bus.busy[0], 0);
    repeat (5) cyc();
    chk("d0_lit_cycles", n_lit[0], 0);

    // 2 then 1 queued: 3 contiguous periods, two dones, no overrun.
    clr_tally();
    strobe(0, 2); s = edge_no;
    repeat (5) cyc();
    strobe(0, 1);
    repeat (40) cyc();
    chk("q_done_count", n_done[0], 2);
    chk("q_overrun", n_ovr[0], 0);
    chk("q_lit_cycles", n_lit[0], 12);
    chk("q_last_done", last_done[0] - s, 30);

    // 2, then 1 and 5 while flashing: 5 overwrites 1.
    clr_tally();
    strobe(0, 2); s = edge_no;
    repeat (3) cyc();
    strobe(0, 1);
    repeat (3) cyc();
    strobe(0, 5);
    repeat (80) cyc();
    chk("ov_overrun", n_ovr[0], 1);
    chk("ov_done_count", n_done[0], 2);
    chk("ov_lit_cycles", n_lit[0], 28);
    chk("ov_last_done", last_done[0] - s, 70);

    // Two channels offset by 3 cycles, then reset mid-run: no done pulses.
    clr_tally();
    strobe(0, 2);
    repeat (2) cyc();
    strobe(1, 4);
    repeat (10) cyc();
    chk("two_busy", bus.busy, 2'b11);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_busy", bus.busy, '0);
    chk("mid_rst_led", bus.led, {CH{AL}});
    repeat (40) cyc();
    chk("mid_rst_dones", n_done[0] + n_done[1], 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 19) == 0) begin
          bus.data_ready[c] = 1'b1;
          bus.data[c*CW +: CW] = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 15))
                                                              : CW'($urandom_range(0, 3));
        end
      end
      if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      cyc();
      bus.data_ready = '0;
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
